// File: rtl/xor_gate_16b.sv
// Registered bitwise-XOR unit for the ALU: result plus zero, parity and Hamming-distance flags.
// All outputs come straight from flops; one pair accepted per cycle with single-cycle latency.
module xor_gate_16b #(
    parameter int WIDTH = 16
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             in_valid,
    input  logic [WIDTH-1:0]                 in1,
    input  logic [WIDTH-1:0]                 in2,
    output logic                             out_valid,
    output logic [WIDTH-1:0]                 out,
    output logic                             zero,
    output logic                             parity,
    output logic [$clog2(WIDTH+1)-1:0]       hamming
);

    localparam int HW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] xor_d;
    logic             zero_d;
    logic             parity_d;
    logic [HW-1:0]    hamming_d;

    logic             valid_q;
    logic [WIDTH-1:0] out_q;
    logic             zero_q;
    logic             parity_q;
    logic [HW-1:0]    hamming_q;

    // Every flag is derived from the single XOR vector so the outputs always agree.
    always_comb begin
        xor_d     = in1 ^ in2;
        zero_d    = (xor_d == '0);
        parity_d  = ^xor_d;
        hamming_d = '0;
        for (int i = 0; i < WIDTH; i++) begin
            hamming_d = hamming_d + HW'(xor_d[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q   <= 1'b0;
            out_q     <= '0;
            zero_q    <= 1'b1;
            parity_q  <= 1'b0;
            hamming_q <= '0;
        end else begin
            valid_q <= in_valid;
            // Results only load on an accepted pair; idle cycles hold the last result.
            if (in_valid) begin
                out_q     <= xor_d;
                zero_q    <= zero_d;
                parity_q  <= parity_d;
                hamming_q <= hamming_d;
            end
        end
    end

    assign out_valid = valid_q;
    assign out       = out_q;
    assign zero      = zero_q;
    assign parity    = parity_q;
    assign hamming   = hamming_q;

endmodule

// File: tb/tb_xor_gate_16b.sv
// Scoreboard bench for xor_gate_16b: driver pushes expected results, a negedge monitor pops and compares.
module tb_xor_gate_16b;

    typedef struct packed {
        logic [15:0] o;
        logic        z;
        logic        p;
        logic [4:0]  h;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [15:0] in1;
    logic [15:0] in2;
    logic        out_valid;
    logic [15:0] out;
    logic        zero;
    logic        parity;
    logic [4:0]  hamming;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_txn    = 0;

    xor_gate_16b #(.WIDTH(16)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in1      (in1),
        .in2      (in2),
        .out_valid(out_valid),
        .out      (out),
        .zero     (zero),
        .parity   (parity),
        .hamming  (hamming)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic exp_t model(input logic [15:0] a, input logic [15:0] b);
        exp_t e;
        e.o = a ^ b;
        e.z = (a == b);
        e.p = ^(a ^ b);
        e.h = 5'($countones(a ^ b));
        return e;
    endfunction

    // Drive one pair with its hand-computed (or modelled) expectation; returns 1 time unit after the capture edge.
    task automatic send(input logic [15:0] a, input logic [15:0] b, input exp_t e);
        in_valid = 1'b1;
        in1      = a;
        in2      = b;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_out"},       32'(out),       32'h0);
        check({tag, "_zero"},      32'(zero),      32'h1);
        check({tag, "_parity"},    32'(parity),    32'h0);
        check({tag, "_hamming"},   32'(hamming),   32'h0);
        check({tag, "_out_valid"}, 32'(out_valid), 32'h0);
    endtask

    // Monitor: every presented result must match the oldest outstanding expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out_valid", 32'(out_valid), 32'h0);
                end else begin
                    e = exp_q.pop_front();
                    n_txn++;
                    $display("txn %0d: out=%h zero=%0d parity=%0d hamming=%0d (exp %h %0d %0d %0d)",
                             n_txn, out, zero, parity, hamming, e.o, e.z, e.p, e.h);
                    check("mon_out",     32'(out),     32'(e.o));
                    check("mon_zero",    32'(zero),    32'(e.z));
                    check("mon_parity",  32'(parity),  32'(e.p));
                    check("mon_hamming", 32'(hamming), 32'(e.h));
                end
            end
        end
    end

    initial begin
        logic [15:0] a;
        logic [15:0] b;
        int          wait_cycles;

        in_valid = 1'b0;
        in1      = 16'h0;
        in2      = 16'h0;
        rst_n    = 1'b1;
        #1 rst_n = 1'b0;
        #1 check_reset_state("por");

        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed vectors, expectations computed by hand.
        send(16'hFFFF, 16'h0000, '{o: 16'hFFFF, z: 1'b0, p: 1'b0, h: 5'd16});
        send(16'hA5A5, 16'hA5A5, '{o: 16'h0000, z: 1'b1, p: 1'b0, h: 5'd0});
        send(16'h8000, 16'h0000, '{o: 16'h8000, z: 1'b0, p: 1'b1, h: 5'd1});
        send(16'h1234, 16'h5678, '{o: 16'h444C, z: 1'b0, p: 1'b1, h: 5'd5});

        // Hold: idle cycles with changing operands must not disturb the last result.
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in1 = 16'($urandom);
            in2 = 16'($urandom);
            @(posedge clk);
            #1;
            check("hold_out",       32'(out),       32'h444C);
            check("hold_out_valid", 32'(out_valid), 32'h0);
            check("hold_zero",      32'(zero),      32'h0);
            check("hold_parity",    32'(parity),    32'h1);
            check("hold_hamming",   32'(hamming),   32'd5);
        end

        // Random soak, back-to-back.
        for (int i = 0; i < 20; i++) begin
            a = 16'($urandom);
            b = 16'($urandom);
            send(a, b, model(a, b));
        end

        // Mid-stream reset: this pair is captured but must be discarded at once.
        in_valid = 1'b1;
        in1      = 16'hDEAD;
        in2      = 16'h1234;
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1 check_reset_state("rst_mid");
        @(posedge clk);
        #1 check_reset_state("rst_held");

        @(negedge clk);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        send(16'h00FF, 16'h0F0F, '{o: 16'h0FF0, z: 1'b0, p: 1'b0, h: 5'd8});
        in_valid = 1'b0;

        wait_cycles = 0;
        while (exp_q.size() != 0 && wait_cycles < 10) begin
            @(posedge clk);
            wait_cycles++;
        end
        check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
